// File: rtl/lcd_note_writer.sv
// HD44780 8-bit write-only driver: power-up init, then rewrites a two-character
// note field whenever the converter's {letter, number} differs from what is shown.
module lcd_note_writer #(
    parameter int unsigned PWR_WAIT = 720000,
    parameter int unsigned EN_HIGH  = 24,
    parameter int unsigned CMD_WAIT = 2400,
    parameter int unsigned CLR_WAIT = 96000,
    parameter logic [6:0]  ADDR     = 7'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] letter,
    input  logic [7:0] number,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       init_done
);

    localparam int unsigned MaxWait = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int unsigned CntW    = $clog2(MaxWait + 1);

    localparam logic [CntW-1:0] PwrLast   = CntW'(PWR_WAIT);
    localparam logic [CntW-1:0] PulseLast = CntW'(EN_HIGH - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_WAIT - 1);
    localparam logic [CntW-1:0] ClrLast   = CntW'(CLR_WAIT - 1);

    typedef enum logic [2:0] {
        StPwrup, StInit, StIdle, StWrAddr, StWrCh1, StWrCh2
    } state_e;

    typedef enum logic [1:0] {
        PhSetup, PhPulse, PhWait
    } phase_e;

    state_e          state_q;
    phase_e          phase_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      init_idx_q;
    logic [15:0]     shown_q;
    logic [15:0]     snap_q;
    logic            lcd_rs_q;
    logic            lcd_e_q;
    logic [7:0]      lcd_db_q;
    logic            busy_q;
    logic            init_done_q;

    state_e          nxt_state;
    logic [1:0]      nxt_idx;
    logic            nxt_rs;
    logic [7:0]      nxt_db;
    logic            nxt_idle;
    logic [CntW-1:0] wait_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Only the Clear Display command needs the long post-pulse wait.
    always_comb begin
        wait_last = (!lcd_rs_q && lcd_db_q == 8'h01) ? ClrLast : CmdLast;
    end

    // What follows the transfer currently in flight.
    always_comb begin
        nxt_state = state_q;
        nxt_idx   = init_idx_q;
        nxt_rs    = 1'b0;
        nxt_db    = lcd_db_q;
        nxt_idle  = 1'b0;
        case (state_q)
            StInit: begin
                if (init_idx_q == 2'd3) begin
                    nxt_idle = 1'b1;
                end else begin
                    nxt_idx = init_idx_q + 2'd1;
                    nxt_db  = init_cmd(init_idx_q + 2'd1);
                end
            end
            StWrAddr: begin
                nxt_state = StWrCh1;
                nxt_rs    = 1'b1;
                nxt_db    = snap_q[15:8];
            end
            StWrCh1: begin
                nxt_state = StWrCh2;
                nxt_rs    = 1'b1;
                nxt_db    = snap_q[7:0];
            end
            default: nxt_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StPwrup;
            phase_q     <= PhSetup;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            shown_q     <= 16'h2020;
            snap_q      <= 16'h2020;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_db_q    <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StPwrup: begin
                    if (cnt_q == PwrLast) begin
                        state_q    <= StInit;
                        phase_q    <= PhSetup;
                        init_idx_q <= 2'd0;
                        lcd_rs_q   <= 1'b0;
                        lcd_db_q   <= init_cmd(2'd0);
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StIdle: begin
                    if ({letter, number} != shown_q) begin
                        snap_q   <= {letter, number};
                        busy_q   <= 1'b1;
                        state_q  <= StWrAddr;
                        phase_q  <= PhSetup;
                        lcd_rs_q <= 1'b0;
                        lcd_db_q <= {1'b1, ADDR};
                        cnt_q    <= '0;
                    end
                end
                default: begin
                    case (phase_q)
                        PhSetup: begin
                            phase_q <= PhPulse;
                            lcd_e_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                        PhPulse: begin
                            if (cnt_q == PulseLast) begin
                                phase_q <= PhWait;
                                lcd_e_q <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CntW'(1);
                            end
                        end
                        default: begin
                            if (cnt_q == wait_last) begin
                                cnt_q   <= '0;
                                phase_q <= PhSetup;
                                if (nxt_idle) begin
                                    state_q <= StIdle;
                                    busy_q  <= 1'b0;
                                    if (state_q == StInit) init_done_q <= 1'b1;
                                    if (state_q == StWrCh2) shown_q <= snap_q;
                                end else begin
                                    state_q    <= nxt_state;
                                    init_idx_q <= nxt_idx;
                                    lcd_rs_q   <= nxt_rs;
                                    lcd_db_q   <= nxt_db;
                                end
                            end else begin
                                cnt_q <= cnt_q + CntW'(1);
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_q;
    assign lcd_db    = lcd_db_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_note_writer.sv
// Scoreboard bench: expected LCD transfers are queued by the stimulus and popped
// by monitors on every lcd_e rising edge.
module tb_lcd_note_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] letter = 8'h20;
    logic [7:0] number = 8'h20;
    logic [7:0] letter_b = 8'h20;
    logic [7:0] number_b = 8'h20;
    logic       lcd_rs, lcd_rw, lcd_e, busy, init_done;
    logic [7:0] lcd_db;
    logic       lcd_rs_b, lcd_rw_b, lcd_e_b, busy_b, init_done_b;
    logic [7:0] lcd_db_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t qb[$];

    lcd_note_writer #(
        .PWR_WAIT(20), .EN_HIGH(2), .CMD_WAIT(5), .CLR_WAIT(10), .ADDR(7'h00)
    ) u_dut (
        .clk(clk), .reset(reset), .letter(letter), .number(number),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
        .busy(busy), .init_done(init_done)
    );

    lcd_note_writer #(
        .PWR_WAIT(20), .EN_HIGH(2), .CMD_WAIT(5), .CLR_WAIT(10), .ADDR(7'h40)
    ) u_dut_b (
        .clk(clk), .reset(reset), .letter(letter_b), .number(number_b),
        .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b), .lcd_e(lcd_e_b), .lcd_db(lcd_db_b),
        .busy(busy_b), .init_done(init_done_b)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval after the k-th posedge following reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - 1);
        end
    endtask

    task automatic push_a(input logic rs, input logic [7:0] db, input int c);
        exp_t e;
        e.rs = rs; e.db = db; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic push_b(input logic rs, input logic [7:0] db, input int c);
        exp_t e;
        e.rs = rs; e.db = db; e.cyc = c;
        qb.push_back(e);
    endtask

    task automatic push_init();
        push_a(1'b0, 8'h38, 21);
        push_a(1'b0, 8'h0C, 29);
        push_a(1'b0, 8'h01, 37);
        push_a(1'b0, 8'h06, 50);
    endtask

    task automatic wait_cycle(input int k);
        int n = 0;
        while (cyc - 1 != k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL wait_cycle: cycle %0d never reached", k);
        end
    endtask

    // Monitor for the ADDR=0 instance: every pulse must match the queue head.
    initial begin
        logic       prev_e = 1'b0;
        int         wid = 0;
        logic [8:0] held = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_e = 1'b0;
                wid = 0;
            end else begin
                if (lcd_e && !prev_e) begin
                    held = {lcd_rs, lcd_db};
                    chk("rw_low", lcd_rw, 1'b0);
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse: got rs=%0b db=%0h, expected no pulse",
                                 lcd_rs, lcd_db);
                    end else begin
                        e = sbq.pop_front();
                        chk("pulse_rs", lcd_rs, e.rs);
                        chk("pulse_db", lcd_db, e.db);
                        chk("rise_cycle", cyc - 1, e.cyc);
                    end
                end else if (lcd_e) begin
                    chk("bus_stable", {lcd_rs, lcd_db}, held);
                end
                if (lcd_e) wid++;
                else if (prev_e) begin
                    chk("e_width", wid, 2);
                    wid = 0;
                end
                prev_e = lcd_e;
            end
        end
    end

    // Monitor for the ADDR=40 instance; only post-init writes are of interest.
    initial begin
        logic prev_e = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_e = 1'b0;
            end else begin
                if (lcd_e_b && !prev_e && init_done_b) begin
                    if (qb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse_b: got rs=%0b db=%0h, expected no pulse",
                                 lcd_rs_b, lcd_db_b);
                    end else begin
                        e = qb.pop_front();
                        chk("b_rs", lcd_rs_b, e.rs);
                        chk("b_db", lcd_db_b, e.db);
                        chk("b_rise_cycle", cyc - 1, e.cyc);
                    end
                end
                prev_e = lcd_e_b;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b1;
        #1;
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_db", lcd_db, 8'h00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_init_done", init_done, 1'b0);
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b0;

        wait_cycle(56);
        chk("init_done_56", init_done, 1'b0);
        chk("busy_56", busy, 1'b1);
        wait_cycle(57);
        chk("init_done_57", init_done, 1'b1);
        chk("busy_57", busy, 1'b0);

        // "C4" from idle: three writes, busy for exactly 24 cycles.
        wait_cycle(70);
        push_a(1'b0, 8'h80, 72);
        push_a(1'b1, 8'h43, 80);
        push_a(1'b1, 8'h34, 88);
        letter = 8'h43;
        number = 8'h34;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("busy_len", n, 24);

        // Blank, then "C4" changed to "A4" mid WR_CH1 pulse.
        wait_cycle(110);
        push_a(1'b0, 8'h80, 112);
        push_a(1'b1, 8'h20, 120);
        push_a(1'b1, 8'h20, 128);
        letter = 8'h20;
        number = 8'h20;
        wait_cycle(150);
        push_a(1'b0, 8'h80, 152);
        push_a(1'b1, 8'h43, 160);
        push_a(1'b1, 8'h34, 168);
        push_a(1'b0, 8'h80, 177);
        push_a(1'b1, 8'h41, 185);
        push_a(1'b1, 8'h34, 193);
        letter = 8'h43;
        number = 8'h34;
        wait_cycle(160);
        letter = 8'h41;
        wait_cycle(215);
        chk("sb_empty_1", sbq.size(), 0);

        // Reset in the middle of the Clear command's enable pulse.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b0;
        wait_cycle(37);
        chk("e_high_pre_reset", lcd_e, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_e", lcd_e, 1'b0);
        chk("async_init_done", init_done, 1'b0);
        chk("async_db", lcd_db, 8'h00);
        chk("async_busy", busy, 1'b1);
        chk("sb_pending_06", sbq.size(), 1);
        sbq.delete();

        // Restart with inputs toggling every cycle through the first IDLE cycle.
        repeat (3) @(negedge clk);
        push_init();
        push_a(1'b0, 8'h80, 59);
        push_a(1'b1, 8'h44, 67);
        push_a(1'b1, 8'h32, 75);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            letter = ((cyc - 1) % 2 == 1) ? 8'h44 : 8'h45;
            number = ((cyc - 1) % 2 == 1) ? 8'h32 : 8'h33;
        end while (cyc - 1 < 57 && n < 200);
        wait_cycle(57);
        chk("init_done_again", init_done, 1'b1);
        wait_cycle(100);
        chk("sb_empty_2", sbq.size(), 0);

        // ADDR=40 instance shows "G5".
        wait_cycle(110);
        push_b(1'b0, 8'hC0, 112);
        push_b(1'b1, 8'h47, 120);
        push_b(1'b1, 8'h35, 128);
        letter_b = 8'h47;
        number_b = 8'h35;
        wait_cycle(145);
        chk("qb_empty", qb.size(), 0);
        chk("sb_empty_3", sbq.size(), 0);

        // Reset from IDLE drops init_done without a clock edge.
        #1 reset = 1'b1;
        #1;
        chk("idle_rst_init_done", init_done, 1'b0);
        chk("idle_rst_busy", busy, 1'b1);
        chk("idle_rst_rs", lcd_rs, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
